// File: rtl/wb_pkg.sv
// Shared widths and the queued-result record for the register-file writeback path.
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue with a parallel, age-ordered view of every entry for bypass search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        push_entry,
  output wb_entry_t        age_entry [DEPTH],
  output logic [DEPTH-1:0] age_valid,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from count, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= push_entry;
  end

  // Index 0 is the head (oldest); higher indices are progressively younger.
  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    logic [PTR_W-1:0] idx;
    assign idx          = head + PTR_W'(i);
    assign age_entry[i] = mem[idx];
    assign age_valid[i] = (CNT_W'(i) < count);
  end

endmodule

// File: rtl/wb_writer.sv
// Writeback producer: accepts execute results, queues them, retires one register-file write
// per cycle and exposes queued-but-unwritten results to readers through two bypass ports.
module wb_writer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] Writereg,
  output logic [DATA_W-1:0] WriteData,
  output logic              Regwrite,
  input  logic [ADDR_W-1:0] q_rr1,
  input  logic [ADDR_W-1:0] q_rr2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp1_data,
  output logic [DATA_W-1:0] byp2_data,
  output logic [CNT_W-1:0]  count
);

  wb_entry_t        age_entry [DEPTH];
  logic [DEPTH-1:0] age_valid;
  wb_entry_t        push_entry;
  logic             accept;
  logic             push;
  logic             pop;

  assign in_ready   = !flush && (count < CNT_W'(DEPTH));
  assign accept     = in_valid && in_ready;
  // Results with no architectural destination complete the handshake but never occupy a slot.
  assign push       = accept && in_we && (in_rd != '0);
  assign pop        = !flush && !stall && (count != '0);
  assign push_entry = '{rd: in_rd, data: in_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .age_entry  (age_entry),
    .age_valid  (age_valid),
    .count      (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Regwrite  <= 1'b0;
      Writereg  <= '0;
      WriteData <= '0;
    end else begin
      Regwrite <= pop;
      if (pop) begin
        Writereg  <= age_entry[0].rd;
        WriteData <= age_entry[0].data;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byp1_hit  = 1'b0;
    byp1_data = '0;
    byp2_hit  = 1'b0;
    byp2_data = '0;
    // Scanning oldest to youngest lets the youngest match overwrite earlier ones.
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (q_rr1 != '0) && (age_entry[i].rd == q_rr1)) begin
        byp1_hit  = 1'b1;
        byp1_data = age_entry[i].data;
      end
      if (age_valid[i] && (q_rr2 != '0) && (age_entry[i].rd == q_rr2)) begin
        byp2_hit  = 1'b1;
        byp2_data = age_entry[i].data;
      end
    end
  end

endmodule
